// File: rtl/output_port_arbiter_if.sv
// rtl/output_port_arbiter_if.sv - input-unit, downstream and status signals of one router output port
interface output_port_arbiter_if;
  logic [4:0]   req;
  logic [4:0]   push_i;
  logic [319:0] flits_in;
  logic         ds_ready;
  logic [4:0]   vc_grant;
  logic [4:0]   st_ack;
  logic [63:0]  flit_out;
  logic         push_out;
  logic         busy;
  logic         wd_err;

  modport master (
    output req, push_i, flits_in, ds_ready,
    input  vc_grant, st_ack, flit_out, push_out, busy, wd_err
  );

  modport slave (
    input  req, push_i, flits_in, ds_ready,
    output vc_grant, st_ack, flit_out, push_out, busy, wd_err
  );
endinterface

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin packet-locking output port arbiter; XFER watchdog under OA_WATCHDOG_EN
module output_port_arbiter #(
  parameter int PKT_LEN = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, XFER} state_t;

  state_t        state_q, state_n;
  logic [2:0]    win_q, win_n;
  logic [2:0]    ptr_q, ptr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [4:0]    vc_grant_q, vc_grant_n;
  logic [4:0]    st_ack_q, st_ack_n;
  logic [63:0]   flit_out_q, flit_out_n;
  logic          push_out_q, push_out_n;
  logic          busy_q, busy_n;
  logic          wd_err_q, wd_err_n;

  logic [2:0]    rr_win;
  logic          rr_found;
  logic [4:0]    win_onehot;
  logic [63:0]   sel_flit;
  logic          sel_push;
  logic [CW-1:0] cnt_inc;

`ifdef OA_WATCHDOG_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_n;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Scan starts just past the last winner, so it has lowest priority now
  always_comb begin
    rr_win   = ptr_q;
    rr_found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      int         idx;
      logic [2:0] i3;
      idx = int'(ptr_q) + k;
      if (idx >= 5) idx = idx - 5;
      i3 = 3'(idx);
      if (!rr_found && bus.req[i3]) begin
        rr_win   = i3;
        rr_found = 1'b1;
      end
    end
  end

  assign win_onehot = 5'b00001 << win_q;
  assign sel_flit   = bus.flits_in[{win_q, 6'b000000} +: 64];
  assign sel_push   = bus.push_i[win_q];
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    state_n    = state_q;
    win_n      = win_q;
    ptr_n      = ptr_q;
    cnt_n      = cnt_q;
    vc_grant_n = 5'b00000;
    st_ack_n   = 5'b00000;
    flit_out_n = flit_out_q;
    push_out_n = 1'b0;
    wd_err_n   = 1'b0;
`ifdef OA_WATCHDOG_EN
    idle_n     = idle_q;
`endif
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          win_n   = rr_win;
          ptr_n   = rr_win;
          state_n = GRANT;
        end
      end
      GRANT: begin
        vc_grant_n = win_onehot;
        state_n    = WAIT;
      end
      WAIT: begin
        // Downstream credit is reserved here; XFER never looks at ds_ready
        if (bus.ds_ready) begin
          st_ack_n = win_onehot;
          cnt_n    = '0;
          state_n  = XFER;
`ifdef OA_WATCHDOG_EN
          idle_n   = '0;
`endif
        end
      end
      XFER: begin
        if (sel_push) begin
          flit_out_n = sel_flit;
          push_out_n = 1'b1;
          cnt_n      = cnt_inc;
`ifdef OA_WATCHDOG_EN
          idle_n     = '0;
`endif
          if (sel_flit[63:62] == 2'b10 || cnt_inc == CW'(PKT_LEN)) state_n = IDLE;
        end
`ifdef OA_WATCHDOG_EN
        else if (idle_q + 1'b1 == IW'(TIMEOUT)) begin
          wd_err_n = 1'b1;
          idle_n   = '0;
          state_n  = IDLE;
        end else begin
          idle_n = idle_q + 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_q      <= 3'd0;
      ptr_q      <= 3'd4;
      cnt_q      <= '0;
      vc_grant_q <= 5'b00000;
      st_ack_q   <= 5'b00000;
      flit_out_q <= 64'd0;
      push_out_q <= 1'b0;
      busy_q     <= 1'b0;
      wd_err_q   <= 1'b0;
`ifdef OA_WATCHDOG_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_n;
      win_q      <= win_n;
      ptr_q      <= ptr_n;
      cnt_q      <= cnt_n;
      vc_grant_q <= vc_grant_n;
      st_ack_q   <= st_ack_n;
      flit_out_q <= flit_out_n;
      push_out_q <= push_out_n;
      busy_q     <= busy_n;
      wd_err_q   <= wd_err_n;
`ifdef OA_WATCHDOG_EN
      idle_q     <= idle_n;
`endif
    end
  end

  assign bus.vc_grant = vc_grant_q;
  assign bus.st_ack   = st_ack_q;
  assign bus.flit_out = flit_out_q;
  assign bus.push_out = push_out_q;
  assign bus.busy     = busy_q;
  assign bus.wd_err   = wd_err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - directed self-checking bench for output_port_arbiter
module tb_output_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  output_port_arbiter_if bus ();

  output_port_arbiter #(.PKT_LEN(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mkflit(input int i, input int j, input bit tail);
    return {(tail ? 2'b10 : 2'b00), 6'd0, 8'(i), 16'hC0DE, 32'(j)};
  endfunction

  task automatic set_flits(input int w, input logic [63:0] f);
    for (int i = 0; i < 5; i++)
      bus.flits_in[64*i +: 64] = (i == w) ? f : {$urandom, $urandom};
  endtask

  // One packet from input w: lock, grant, ack, then n flits (tail at tail_pos, -1 for none)
  task automatic drive_packet(input int w, input int n, input int tail_pos,
                              input logic [4:0] req_val, input logic [4:0] req_after);
    logic [4:0]  oh;
    logic [63:0] f;
    oh = 5'b00001 << w;
    bus.req = req_val;
    bus.ds_ready = 1'b1;
    bus.push_i = 5'b00000;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.push_out !== 1'b0 || bus.vc_grant !== 5'b00000) begin
      errors++;
      $display("FAIL lock w=%0d: busy=%b push_out=%b vc_grant=%b expected 1 0 00000", w, bus.busy, bus.push_out, bus.vc_grant);
    end
    bus.req = req_after;
    tick();
    checks++;
    if (bus.vc_grant !== oh || bus.st_ack !== 5'b00000) begin
      errors++;
      $display("FAIL vc_grant w=%0d: vc_grant=%b st_ack=%b expected %b 00000", w, bus.vc_grant, bus.st_ack, oh);
    end
    tick();
    checks++;
    if (bus.vc_grant !== 5'b00000 || bus.st_ack !== oh) begin
      errors++;
      $display("FAIL st_ack w=%0d: vc_grant=%b st_ack=%b expected 00000 %b", w, bus.vc_grant, bus.st_ack, oh);
    end
    for (int j = 0; j < n; j++) begin
      f = mkflit(w, j, j == tail_pos);
      set_flits(w, f);
      bus.push_i = 5'b11111;
      tick();
      checks++;
      if (bus.push_out !== 1'b1 || bus.flit_out !== f || bus.st_ack !== 5'b00000) begin
        errors++;
        $display("FAIL flit w=%0d j=%0d: push_out=%b flit_out=%h st_ack=%b expected 1 %h 00000", w, j, bus.push_out, bus.flit_out, bus.st_ack, f);
      end
      checks++;
      if (bus.busy !== (j != n - 1)) begin
        errors++;
        $display("FAIL busy w=%0d j=%0d: busy=%b expected %b", w, j, bus.busy, (j != n - 1));
      end
    end
    bus.push_i = 5'b00000;
  endtask

  task automatic test_reset();
    bus.req = 5'b00000;
    bus.push_i = 5'b00000;
    bus.flits_in = '0;
    bus.ds_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.vc_grant !== 5'b00000 || bus.st_ack !== 5'b00000 || bus.flit_out !== 64'd0 ||
        bus.push_out !== 1'b0 || bus.busy !== 1'b0 || bus.wd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: vc_grant=%b st_ack=%b flit_out=%h push_out=%b busy=%b wd_err=%b expected all 0",
               bus.vc_grant, bus.st_ack, bus.flit_out, bus.push_out, bus.busy, bus.wd_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    drive_packet(2, 4, -1, 5'b00100, 5'b00000);
    tick();
    checks++;
    if (bus.push_out !== 1'b0 || bus.busy !== 1'b0 || bus.vc_grant !== 5'b00000) begin
      errors++;
      $display("FAIL basic_idle: push_out=%b busy=%b vc_grant=%b expected 0 0 00000", bus.push_out, bus.busy, bus.vc_grant);
    end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 4, 0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++)
      drive_packet(order[k], 1, 0, 5'b11111, (k == 5) ? 5'b00000 : 5'b11111);
  endtask

  task automatic test_wait();
    bus.req = 5'b00010;
    bus.ds_ready = 1'b0;
    tick();
    bus.req = 5'b00000;
    tick();
    checks++;
    if (bus.vc_grant !== 5'b00010) begin
      errors++;
      $display("FAIL wait_grant: vc_grant=%b expected 00010", bus.vc_grant);
    end
    set_flits(1, 64'hDEAD_BEEF_0000_0001);
    bus.push_i = 5'b00010;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (bus.st_ack !== 5'b00000 || bus.push_out !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_hold k=%0d: st_ack=%b push_out=%b busy=%b expected 00000 0 1", k, bus.st_ack, bus.push_out, bus.busy);
      end
    end
    bus.ds_ready = 1'b1;
    tick();
    checks++;
    if (bus.st_ack !== 5'b00010 || bus.push_out !== 1'b0) begin
      errors++;
      $display("FAIL wait_ack: st_ack=%b push_out=%b expected 00010 0", bus.st_ack, bus.push_out);
    end
    for (int j = 0; j < 4; j++) begin
      set_flits(1, mkflit(1, j, 1'b0));
      tick();
      checks++;
      if (bus.push_out !== 1'b1 || bus.flit_out !== mkflit(1, j, 1'b0) || bus.busy !== (j != 3)) begin
        errors++;
        $display("FAIL wait_flit j=%0d: push_out=%b flit_out=%h busy=%b expected 1 %h %b", j, bus.push_out, bus.flit_out, bus.busy, mkflit(1, j, 1'b0), (j != 3));
      end
    end
    bus.push_i = 5'b00000;
  endtask

  task automatic test_tail();
    drive_packet(2, 2, 1, 5'b01100, 5'b01000);
    drive_packet(3, 4, -1, 5'b01000, 5'b00000);
  endtask

  task automatic test_reset_mid();
    bus.req = 5'b00001;
    bus.ds_ready = 1'b1;
    tick();
    bus.req = 5'b00000;
    tick();
    tick();
    checks++;
    if (bus.st_ack !== 5'b00001) begin
      errors++;
      $display("FAIL mid_ack: st_ack=%b expected 00001", bus.st_ack);
    end
    bus.push_i = 5'b00001;
    for (int j = 0; j < 2; j++) begin
      set_flits(0, mkflit(0, j, 1'b0));
      tick();
    end
    checks++;
    if (bus.push_out !== 1'b1 || bus.flit_out !== mkflit(0, 1, 1'b0)) begin
      errors++;
      $display("FAIL mid_flit: push_out=%b flit_out=%h expected 1 %h", bus.push_out, bus.flit_out, mkflit(0, 1, 1'b0));
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.vc_grant !== 5'b00000 || bus.st_ack !== 5'b00000 || bus.flit_out !== 64'd0 ||
        bus.push_out !== 1'b0 || bus.busy !== 1'b0 || bus.wd_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: vc_grant=%b st_ack=%b flit_out=%h push_out=%b busy=%b wd_err=%b expected all 0",
               bus.vc_grant, bus.st_ack, bus.flit_out, bus.push_out, bus.busy, bus.wd_err);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.push_out !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_drop: push_out=%b busy=%b expected 0 0", bus.push_out, bus.busy);
    end
    bus.push_i = 5'b00000;
    drive_packet(0, 4, -1, 5'b00011, 5'b00000);
  endtask

  task automatic test_watchdog();
    bus.req = 5'b00010;
    bus.ds_ready = 1'b1;
    tick();
    bus.req = 5'b00000;
    tick();
    tick();
    set_flits(1, mkflit(1, 0, 1'b0));
    bus.push_i = 5'b00010;
    tick();
    checks++;
    if (bus.push_out !== 1'b1 || bus.flit_out !== mkflit(1, 0, 1'b0)) begin
      errors++;
      $display("FAIL wd_first: push_out=%b flit_out=%h expected 1 %h", bus.push_out, bus.flit_out, mkflit(1, 0, 1'b0));
    end
    bus.push_i = 5'b00000;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (bus.wd_err !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL wd_idle k=%0d: wd_err=%b busy=%b expected 0 1", k, bus.wd_err, bus.busy);
      end
    end
    tick();
`ifdef OA_WATCHDOG_EN
    checks++;
    if (bus.wd_err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_fire: wd_err=%b busy=%b expected 1 0", bus.wd_err, bus.busy);
    end
    tick();
    checks++;
    if (bus.wd_err !== 1'b0 || bus.busy !== 1'b0 || bus.push_out !== 1'b0) begin
      errors++;
      $display("FAIL wd_after: wd_err=%b busy=%b push_out=%b expected 0 0 0", bus.wd_err, bus.busy, bus.push_out);
    end
`else
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.wd_err !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL wd_off k=%0d: wd_err=%b busy=%b expected 0 1", k, bus.wd_err, bus.busy);
      end
      tick();
    end
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_wait();
    test_tail();
    test_reset_mid();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
